// File: rtl/wb_write_sequencer_if.sv
// Retire, issue, hazard-query and register-file write signals of the
// write-back sequencer, bundled into one interface.
interface wb_write_sequencer_if;
  // Retire channel
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_dst_en;
  logic [3:0]  wb_dst;
  logic [63:0] wb_data;
  logic        wb_ext_en;
  logic [63:0] wb_ext_data;
  logic [1:0]  wb_rsp_op;
  logic        wb_store;
  // Issue-side scoreboard marks
  logic        iss_valid;
  logic        iss_dst_en;
  logic [3:0]  iss_dst;
  logic        iss_ext;
  logic        iss_rsp;
  logic        iss_ready;
  // Source-operand hazard query
  logic [3:0]  rd_a;
  logic [3:0]  rd_b;
  logic        hazard;
  // Register file side
  logic [63:0] rf_rsp;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        store_writeback;
  logic [15:0] sb_busy;

  modport master (
    output wb_valid, wb_dst_en, wb_dst, wb_data, wb_ext_en, wb_ext_data,
           wb_rsp_op, wb_store, iss_valid, iss_dst_en, iss_dst, iss_ext,
           iss_rsp, rd_a, rd_b, rf_rsp,
    input  wb_ready, iss_ready, hazard, rf_we, rf_waddr, rf_wdata,
           store_writeback, sb_busy
  );

  modport slave (
    input  wb_valid, wb_dst_en, wb_dst, wb_data, wb_ext_en, wb_ext_data,
           wb_rsp_op, wb_store, iss_valid, iss_dst_en, iss_dst, iss_ext,
           iss_rsp, rd_a, rd_b, rf_rsp,
    output wb_ready, iss_ready, hazard, rf_we, rf_waddr, rf_wdata,
           store_writeback, sb_busy
  );
endinterface

// File: rtl/wb_write_sequencer.sv
// Write-back sequencer: serialises up to three register writes of one
// retiring instruction (RSP update, RDX extension, primary destination)
// onto a single register-file write port and tracks busy registers.
module wb_write_sequencer (
  input  logic                 clk,
  input  logic                 reset_n,
  wb_write_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, W_RSP, W_EXT, W_DST} state_t;

  localparam logic [3:0] REG_RDX = 4'd2;
  localparam logic [3:0] REG_RSP = 4'd4;

  state_t      r_state;
  state_t      w_state_nxt;

  // Retire fields captured on acceptance
  logic        r_dst_en;
  logic [3:0]  r_dst;
  logic [63:0] r_data;
  logic        r_ext_en;
  logic [63:0] r_ext_data;
  logic [1:0]  r_rsp_op;
  logic        r_store_pulse;
  logic [15:0] r_sb_busy;

  logic        w_idle;
  logic        w_accept;
  logic        w_in_rsp_en;
  logic        w_r_rsp_en;
  logic        w_rf_we;
  logic [3:0]  w_rf_waddr;
  logic [63:0] w_rf_wdata;
  logic [15:0] w_iss_mask;
  logic [15:0] w_clr_mask;
  logic        w_iss_ready;

  // Only op codes 01 (pop, +8) and 10 (push, -8) touch RSP; 11 is a no-op
  assign w_in_rsp_en = (bus.wb_rsp_op == 2'b01) || (bus.wb_rsp_op == 2'b10);
  assign w_r_rsp_en  = (r_rsp_op == 2'b01) || (r_rsp_op == 2'b10);
  assign w_idle      = (r_state == IDLE);
  assign w_accept    = bus.wb_valid && w_idle;

  // Next write after `cur` in the fixed order RSP, EXT, DST; IDLE when none left.
  // Keeping this order lets the loaded value of a POP into RSP win.
  function automatic state_t next_write(state_t cur, logic rsp_en,
                                        logic ext_en, logic dst_en);
    next_write = IDLE;
    if (cur == IDLE && rsp_en)
      next_write = W_RSP;
    else if ((cur == IDLE || cur == W_RSP) && ext_en)
      next_write = W_EXT;
    else if (cur != W_DST && dst_en)
      next_write = W_DST;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and write-port drive for the current write state
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    w_state_nxt = r_state;
    w_rf_we     = 1'b0;
    w_rf_waddr  = '0;
    w_rf_wdata  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept)
          w_state_nxt = next_write(IDLE, w_in_rsp_en, bus.wb_ext_en, bus.wb_dst_en);
      end
      W_RSP: begin
        w_rf_we     = 1'b1;
        w_rf_waddr  = REG_RSP;
        // rf_rsp is taken live in this cycle; wraps modulo 2^64
        w_rf_wdata  = (r_rsp_op == 2'b01) ? bus.rf_rsp + 64'd8 : bus.rf_rsp - 64'd8;
        w_state_nxt = next_write(W_RSP, w_r_rsp_en, r_ext_en, r_dst_en);
      end
      W_EXT: begin
        w_rf_we     = 1'b1;
        w_rf_waddr  = REG_RDX;
        w_rf_wdata  = r_ext_data;
        w_state_nxt = next_write(W_EXT, w_r_rsp_en, r_ext_en, r_dst_en);
      end
      W_DST: begin
        w_rf_we     = 1'b1;
        w_rf_waddr  = r_dst;
        w_rf_wdata  = r_data;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the retire on acceptance and raise the store pulse for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the captured payload is reset too, so a retire cut short by
    // reset leaves no stale data or pending store pulse behind.
    if (!reset_n) begin
      r_dst_en      <= 1'b0;
      r_dst         <= '0;
      r_data        <= '0;
      r_ext_en      <= 1'b0;
      r_ext_data    <= '0;
      r_rsp_op      <= '0;
      r_store_pulse <= 1'b0;
    end else begin
      r_store_pulse <= w_accept && bus.wb_store;
      if (w_accept) begin
        r_dst_en   <= bus.wb_dst_en;
        r_dst      <= bus.wb_dst;
        r_data     <= bus.wb_data;
        r_ext_en   <= bus.wb_ext_en;
        r_ext_data <= bus.wb_ext_data;
        r_rsp_op   <= bus.wb_rsp_op;
      end
    end
  end

  // Registers targeted by the issue request and by the current write
  always_comb begin
    w_iss_mask = '0;
    w_clr_mask = '0;
    if (bus.iss_dst_en) w_iss_mask[bus.iss_dst] = 1'b1;
    if (bus.iss_ext)    w_iss_mask[REG_RDX]     = 1'b1;
    if (bus.iss_rsp)    w_iss_mask[REG_RSP]     = 1'b1;
    if (w_rf_we)        w_clr_mask[w_rf_waddr]  = 1'b1;
  end

  assign w_iss_ready = ~|(w_iss_mask & r_sb_busy);

  // Scoreboard: clear on write-back, set on issue; a same-cycle set wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_sb_busy <= '0;
    else
      r_sb_busy <= (r_sb_busy & ~w_clr_mask)
                 | ((bus.iss_valid && w_iss_ready) ? w_iss_mask : 16'h0);
  end

  assign bus.wb_ready        = w_idle;
  assign bus.iss_ready       = w_iss_ready;
  assign bus.hazard          = r_sb_busy[bus.rd_a] | r_sb_busy[bus.rd_b];
  assign bus.rf_we           = w_rf_we;
  assign bus.rf_waddr        = w_rf_waddr;
  assign bus.rf_wdata        = w_rf_wdata;
  assign bus.store_writeback = r_store_pulse;
  assign bus.sb_busy         = r_sb_busy;

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Self-checking bench for wb_write_sequencer: directed corner cases followed
// by randomised retires and issues against a list-of-writes reference model.
module tb_wb_write_sequencer;

  logic clk = 1'b0;
  logic reset_n;

  wb_write_sequencer_if bus ();

  wb_write_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
    bit          is_rsp;
    bit          up;
  } wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_busy;
  bit          rnd_iss  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Registers named by the issue request currently on the bus
  function automatic logic [15:0] iss_mask();
    logic [15:0] m;
    m = 16'h0;
    if (bus.iss_dst_en) m = m | (16'h1 << bus.iss_dst);
    if (bus.iss_ext)    m = m | 16'h0004;
    if (bus.iss_rsp)    m = m | 16'h0010;
    return m;
  endfunction

  task automatic set_iss(input bit v, input bit de, input logic [3:0] d, input bit e, input bit r);
    bus.iss_valid  = v;
    bus.iss_dst_en = de;
    bus.iss_dst    = d;
    bus.iss_ext    = e;
    bus.iss_rsp    = r;
  endtask

  task automatic rand_iss();
    if (rnd_iss) begin
      set_iss($urandom_range(0, 2) == 0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      bus.rd_a = 4'($urandom);
      bus.rd_b = 4'($urandom);
    end
  endtask

  // Let combinational outputs settle, then compare scoreboard-side outputs
  task automatic sb_check();
    logic [15:0] m;
    #1;
    m = iss_mask();
    check("iss_ready", 64'(bus.iss_ready), 64'((m & m_busy) == 16'h0));
    check("hazard", 64'(bus.hazard), 64'(m_busy[bus.rd_a] | m_busy[bus.rd_b]));
    check("sb_busy", 64'(bus.sb_busy), 64'(m_busy));
  endtask

  // Update the busy model for this cycle's issue and write, then step a clock
  task automatic advance(input logic [15:0] clr);
    logic [15:0] m;
    bit          rdy;
    m      = iss_mask();
    rdy    = ((m & m_busy) == 16'h0);
    m_busy = (m_busy & ~clr) | ((bus.iss_valid && rdy) ? m : 16'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit de, input logic [3:0] d, input bit e, input bit r);
    set_iss(1'b1, de, d, e, r);
    sb_check();
    advance(16'h0);
    set_iss(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // One retire from acceptance to the cycle wb_ready returns
  task automatic do_retire(input logic [1:0] rsp_op, input bit store,
                           input bit ext_en, input logic [63:0] ext_data,
                           input bit dst_en, input logic [3:0] dst,
                           input logic [63:0] data, input logic [63:0] rsp_val,
                           input bit iss_first, input logic [3:0] iss_first_dst);
    wr_t         q[$];
    wr_t         w;
    logic [63:0] exp;
    if (rsp_op == 2'b01 || rsp_op == 2'b10) begin
      w.addr = 4'd4; w.data = 64'h0; w.is_rsp = 1'b1; w.up = (rsp_op == 2'b01);
      q.push_back(w);
    end
    if (ext_en) begin
      w.addr = 4'd2; w.data = ext_data; w.is_rsp = 1'b0; w.up = 1'b0;
      q.push_back(w);
    end
    if (dst_en) begin
      w.addr = dst; w.data = data; w.is_rsp = 1'b0; w.up = 1'b0;
      q.push_back(w);
    end

    bus.wb_valid    = 1'b1;
    bus.wb_rsp_op   = rsp_op;
    bus.wb_store    = store;
    bus.wb_ext_en   = ext_en;
    bus.wb_ext_data = ext_data;
    bus.wb_dst_en   = dst_en;
    bus.wb_dst      = dst;
    bus.wb_data     = data;
    bus.rf_rsp      = {$urandom, $urandom};
    if (!rnd_iss) bus.iss_valid = 1'b0;
    rand_iss();
    sb_check();
    check("wb_ready_accept", 64'(bus.wb_ready), 64'd1);
    check("rf_we_accept", 64'(bus.rf_we), 64'd0);
    advance(16'h0);

    foreach (q[k]) begin
      // Scramble the retire inputs: the sequencer must use its captured copy
      bus.wb_valid    = rnd_iss ? 1'($urandom) : 1'b0;
      bus.wb_data     = {$urandom, $urandom};
      bus.wb_ext_data = {$urandom, $urandom};
      bus.wb_dst      = 4'($urandom);
      bus.wb_rsp_op   = 2'($urandom);
      bus.wb_ext_en   = 1'($urandom);
      bus.wb_dst_en   = 1'($urandom);
      bus.wb_store    = 1'($urandom);
      bus.rf_rsp      = rsp_val;
      if (iss_first && k == 0) set_iss(1'b1, 1'b1, iss_first_dst, 1'b0, 1'b0);
      else if (!rnd_iss)       bus.iss_valid = 1'b0;
      rand_iss();
      sb_check();
      exp = q[k].is_rsp ? (q[k].up ? rsp_val + 64'd8 : rsp_val - 64'd8) : q[k].data;
      check("rf_we", 64'(bus.rf_we), 64'd1);
      check("rf_waddr", 64'(bus.rf_waddr), 64'(q[k].addr));
      check("rf_wdata", bus.rf_wdata, exp);
      check("store_wb_write", 64'(bus.store_writeback), (k == 0) ? 64'(store) : 64'd0);
      check("wb_ready_busy", 64'(bus.wb_ready), 64'd0);
      advance(16'h1 << q[k].addr);
    end

    bus.wb_valid = 1'b0;
    if (!rnd_iss) bus.iss_valid = 1'b0;
    rand_iss();
    sb_check();
    check("wb_ready_return", 64'(bus.wb_ready), 64'd1);
    check("rf_we_idle", 64'(bus.rf_we), 64'd0);
    check("rf_waddr_idle", 64'(bus.rf_waddr), 64'd0);
    check("rf_wdata_idle", bus.rf_wdata, 64'd0);
    check("store_wb_end", 64'(bus.store_writeback), (q.size() == 0) ? 64'(store) : 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [63:0] rv;
    int          sel;

    // Reset state
    reset_n         = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.wb_dst_en   = 1'b0;
    bus.wb_dst      = 4'd0;
    bus.wb_data     = 64'h0;
    bus.wb_ext_en   = 1'b0;
    bus.wb_ext_data = 64'h0;
    bus.wb_rsp_op   = 2'b00;
    bus.wb_store    = 1'b0;
    bus.rd_a        = 4'd0;
    bus.rd_b        = 4'd0;
    bus.rf_rsp      = 64'h0;
    set_iss(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    m_busy = 16'h0;
    #2;
    check("rst_wb_ready", 64'(bus.wb_ready), 64'd1);
    check("rst_rf_we", 64'(bus.rf_we), 64'd0);
    check("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    check("rst_rf_wdata", bus.rf_wdata, 64'd0);
    check("rst_store_wb", 64'(bus.store_writeback), 64'd0);
    check("rst_sb_busy", 64'(bus.sb_busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain destination write to register 3, which was marked busy at issue
    issue(1'b1, 4'd3, 1'b0, 1'b0);
    do_retire(2'b00, 1'b0, 1'b0, 64'h0, 1'b1, 4'd3, 64'h1234, 64'h0, 1'b0, 4'd0);
    check("sb3_cleared", 64'(bus.sb_busy[3]), 64'd0);

    // PUSH: RSP-8 with a store pulse alongside the first write
    do_retire(2'b10, 1'b1, 1'b0, 64'h0, 1'b0, 4'd0, 64'h0, 64'h1000, 1'b0, 4'd0);
    // IMUL: RDX then register 0
    do_retire(2'b00, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 4'd0, 64'h55, 64'h0, 1'b0, 4'd0);
    // POP into RSP: RSP+8 first, loaded value last
    do_retire(2'b01, 1'b0, 1'b0, 64'h0, 1'b1, 4'd4, 64'hAB, 64'h0, 1'b0, 4'd0);
    // RSP wrap-around in both directions
    do_retire(2'b10, 1'b0, 1'b0, 64'h0, 1'b0, 4'd0, 64'h0, 64'h0, 1'b0, 4'd0);
    do_retire(2'b01, 1'b0, 1'b0, 64'h0, 1'b0, 4'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 4'd0);
    // No writes: op 11 alone, then a bare store completion
    do_retire(2'b11, 1'b0, 1'b0, 64'h0, 1'b0, 4'd0, 64'h0, 64'h0, 1'b0, 4'd0);
    do_retire(2'b00, 1'b1, 1'b0, 64'h0, 1'b0, 4'd0, 64'h0, 64'h0, 1'b0, 4'd0);

    // Scoreboard blocking and hazard on register 5
    issue(1'b1, 4'd5, 1'b0, 1'b0);
    set_iss(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    bus.rd_a = 4'd5;
    sb_check();
    check("iss_blocked_r5", 64'(bus.iss_ready), 64'd0);
    check("hazard_r5", 64'(bus.hazard), 64'd1);
    advance(16'h0);
    set_iss(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    do_retire(2'b00, 1'b0, 1'b0, 64'h0, 1'b1, 4'd5, 64'h77, 64'h0, 1'b0, 4'd0);
    // Issue and write-back of register 5 in the same cycle: set wins
    do_retire(2'b00, 1'b0, 1'b0, 64'h0, 1'b1, 4'd5, 64'h88, 64'h0, 1'b1, 4'd5);
    check("set_wins_r5", 64'(bus.sb_busy[5]), 64'd1);
    bus.rd_a = 4'd0;

    // Reset during W_EXT of a three-write retire
    issue(1'b1, 4'd7, 1'b1, 1'b0);
    bus.wb_valid = 1'b1; bus.wb_rsp_op = 2'b10; bus.wb_store = 1'b1;
    bus.wb_ext_en = 1'b1; bus.wb_ext_data = 64'h1111;
    bus.wb_dst_en = 1'b1; bus.wb_dst = 4'd7; bus.wb_data = 64'h2222;
    sb_check();
    advance(16'h0);
    bus.wb_valid = 1'b0;
    bus.rf_rsp   = 64'h500;
    sb_check();
    check("mid_rsp_addr", 64'(bus.rf_waddr), 64'd4);
    check("mid_rsp_data", bus.rf_wdata, 64'h4F8);
    advance(16'h0010);
    sb_check();
    check("mid_ext_addr", 64'(bus.rf_waddr), 64'd2);
    reset_n = 1'b0;
    m_busy  = 16'h0;
    #1;
    check("rstmid_rf_we", 64'(bus.rf_we), 64'd0);
    check("rstmid_waddr", 64'(bus.rf_waddr), 64'd0);
    check("rstmid_wdata", bus.rf_wdata, 64'd0);
    check("rstmid_sb_busy", 64'(bus.sb_busy), 64'd0);
    check("rstmid_store", 64'(bus.store_writeback), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sb_check();
      check("post_rst_ready", 64'(bus.wb_ready), 64'd1);
      check("post_rst_no_write", 64'(bus.rf_we), 64'd0);
      advance(16'h0);
    end

    // Randomised retires with random issue traffic
    rnd_iss = 1'b1;
    for (int t = 0; t < 250; t++) begin
      op  = 2'($urandom);
      sel = $urandom_range(0, 3);
      rv  = (sel == 0) ? 64'h0 :
            (sel == 1) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
      do_retire(op, 1'($urandom), 1'($urandom), {$urandom, $urandom},
                1'($urandom), 4'($urandom), {$urandom, $urandom}, rv, 1'b0, 4'd0);
      if ($urandom_range(0, 3) == 0) begin
        rand_iss();
        sb_check();
        check("gap_rf_we", 64'(bus.rf_we), 64'd0);
        advance(16'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
